load_store_unit: RTL and testbench
==================================

# load_store_unit

- Initiator-side load/store sequencer between the single-cycle core's MEM stage and a byte-wide data memory port: one request per transaction, one byte per cycle, little-endian.
- Loads: bytes are assembled and sign- or zero-extended to 64 bits per RISC-V funct3.
- Stores: the low 1/2/4/8 bytes of the write data are serialised out.
- The core stalls on `req_ready`/`resp_valid`.

## Interface
Parameters:
- ADDR_W, 64, byte address width (address arithmetic wraps modulo 2^ADDR_W)
- XLEN, 64, register/data width; must be 64

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  unit idle, request accepted when req_valid & req_ready
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V size/sign code
- req_addr  in  ADDR_W  first byte address (any alignment)
- req_wdata  in  XLEN  store data
- resp_valid  out  1  one-cycle pulse, transaction complete
- resp_err  out  1  qualifies resp_valid, illegal funct3
- Read_Data  out  XLEN  extended load result, held until next load completes
- mem_addr  out  ADDR_W  byte address to memory
- mem_wdata  out  8  byte to write
- mem_we  out  1  byte write strobe, memory writes on rising edge
- mem_re  out  1  byte read enable
- mem_rdata  in  8  combinational read byte for current mem_addr

## Operation

**Size decode**
- funct3 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- Byte count N = 1/2/4/8.
- Load 111 → error. Store with funct3[2]=1 → error.

**FSM: IDLE → ACCESS → DONE → IDLE**

IDLE:
- req_ready=1.
- On acceptance, latch write, funct3, addr, wdata; clear byte counter.
- Legal request → ACCESS. Illegal → DONE with err flag set; no memory access.

ACCESS, byte k = 0..N-1:
- mem_addr = addr + k.
- Load: mem_re=1; at the clock edge, mem_rdata captures into assembly lane k.
- Store: mem_we=1, mem_wdata = wdata[8k+7:8k].
- After byte N-1 → DONE.

DONE:
- resp_valid=1 for exactly one cycle; resp_err = err flag.
- Load without error: Read_Data updated with the extended value on entry to DONE.
- Signed sizes replicate the top byte's bit 7; U sizes zero-fill.
- Store or error: Read_Data unchanged.
- Then → IDLE.

**Reset**
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, Read_Data=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0.

**Boundary conditions**
- Reset during ACCESS aborts: bytes already written stay written, no response is produced, and mem_we is low in the cycle after the reset edge.
- Address wrap: 0xFFFF_FFFF_FFFF_FFFF + 1 → 0, no error.
- req_valid while busy is ignored (req_ready=0); the core must hold the request.
- mem_we and mem_re are never both 1, and both are 0 outside ACCESS.

## Timing
- Accept at edge T0. Memory bytes occupy cycles T0+1 .. T0+N. resp_valid is high in cycle T0+N+1. req_ready returns in cycle T0+N+2.
- Illegal request: resp_valid high with resp_err=1 in cycle T0+1.
- Throughput: one N-byte transaction per N+2 cycles.
- Read_Data is valid in the resp_valid cycle and stable afterwards.
- All outputs are registered or decoded from registered state; there is no combinational path from req_* to mem_*.

## Structure
- Package `lsu_pkg`:
  - funct3 localparams (F3_B…F3_WU)
  - state enum {IDLE, ACCESS, DONE}
  - function returning N from funct3
- Sub-module `load_extend`: combinational; takes assembled 64-bit raw data and funct3, returns the sign/zero-extended XLEN value.
- Counter: 3-bit byte index.

## Test plan
- Memory preloaded bytes 0..7 = 83 34 05 0F B3 84 9A 00; LD addr 0 → Read_Data 0x009A84B3_0F053483, resp_valid in cycle T0+9.
- LB addr 0 → 0xFFFF_FFFF_FFFF_FF83; LBU addr 0 → 0x83; LH addr 4 → 0xFFFF_FFFF_FFFF_84B3; LWU addr 4 → 0x009A84B3.
- SW addr 3, wdata 0x1122_3344_5566_7788:
  - Bytes 3..6 = 88 77 66 55; bytes 2 and 7 untouched.
  - Exactly 4 mem_we cycles.
  - Read_Data unchanged.
- Load funct3 111 → no mem_re/mem_we, resp_valid=1 with resp_err=1 in cycle T0+1. SB with funct3 100 → same.
- rst_n low in 2nd ACCESS cycle of SD to addr 8 → only byte 8 written; outputs return to reset values next cycle; no resp_valid.
- Back-to-back: SH addr 0x10 value 0xBEEF, then LHU addr 0x10 held valid → Read_Data 0xBEEF; req_ready low throughout each transaction.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 size codes, the
// sequencer state encoding, and helpers that decode byte count and legality.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    // Byte count N (1/2/4/8) for a funct3 code; funct3[1:0] alone selects size.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        logic [3:0] n;
        unique case (funct3[1:0])
            2'b00:   n = 4'd1;
            2'b01:   n = 4'd2;
            2'b10:   n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    // Loads reject 111 only; stores have no unsigned variants.
    function automatic logic req_legal(input logic write, input logic [2:0] funct3);
        return write ? ~funct3[2] : (funct3 != 3'b111);
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational sign/zero extension of an assembled little-endian load.
//   raw_i    : assembled bytes, lane k = byte k of the access
//   funct3_i : RISC-V load size/sign code
//   ext_o    : extended XLEN result
module load_extend
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [63:0]     raw_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] ext_o
);

    always_comb begin
        ext_o = raw_i;
        unique case (funct3_i)
            F3_B:    ext_o = {{56{raw_i[7]}}, raw_i[7:0]};
            F3_H:    ext_o = {{48{raw_i[15]}}, raw_i[15:0]};
            F3_W:    ext_o = {{32{raw_i[31]}}, raw_i[31:0]};
            F3_D:    ext_o = raw_i;
            F3_BU:   ext_o = {56'd0, raw_i[7:0]};
            F3_HU:   ext_o = {48'd0, raw_i[15:0]};
            F3_WU:   ext_o = {32'd0, raw_i[31:0]};
            default: ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between the core MEM stage and a byte-wide memory port.
// One request per transaction, one byte per cycle, little-endian.
//   clk, rst_n              : clock, synchronous active-low reset
//   req_valid/req_ready     : request handshake (ready only when idle)
//   req_write/req_funct3    : store flag and RISC-V size/sign code
//   req_addr/req_wdata      : first byte address and store data
//   resp_valid/resp_err     : one-cycle completion pulse and illegal-funct3 flag
//   Read_Data               : extended load result, held until the next load
//   mem_addr/mem_wdata      : byte address and write byte
//   mem_we/mem_re/mem_rdata : write strobe, read enable, combinational read byte
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned XLEN   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [XLEN-1:0]   Read_Data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [63:0]       raw_q, raw_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;

    logic [3:0]      n_bytes;
    logic [2:0]      last_idx;
    logic [XLEN-1:0] ext_val;
    logic            in_access;

    assign n_bytes   = size_bytes(f3_q);
    assign last_idx  = 3'(n_bytes - 4'd1);
    assign in_access = (state_q == StAccess);

    // Assembly lane k takes the current read byte; kept apart from the FSM block
    // so the extender sees the final byte in the same cycle it arrives.
    always_comb begin
        raw_d = raw_q;
        if (in_access && !write_q) begin
            raw_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
        end
    end

    load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .raw_i   (raw_d),
        .funct3_i(f3_q),
        .ext_o   (ext_val)
    );

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d = req_write;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 3'd0;
                    err_d   = ~req_legal(req_write, req_funct3);
                    state_d = req_legal(req_write, req_funct3) ? StAccess : StDone;
                end
            end
            StAccess: begin
                if (cnt_q == last_idx) begin
                    state_d = StDone;
                    if (!write_q) begin
                        rdata_d = ext_val;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 3'd0;
            err_q   <= 1'b0;
            raw_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            raw_q   <= raw_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StDone);
    assign resp_err   = resp_valid & err_q;
    assign Read_Data  = rdata_q;

    // Strobes are qualified by rst_n so a reset asserted mid-access stops the
    // byte in flight from landing at the reset edge.
    assign mem_we    = in_access & write_q & rst_n;
    assign mem_re    = in_access & ~write_q & rst_n;
    assign mem_addr  = in_access ? addr_q + ADDR_W'(cnt_q) : '0;
    assign mem_wdata = (in_access && write_q) ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'd0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [63:0] Read_Data, mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we, mem_re;

    logic [7:0] mem [0:255];
    logic       pl_en;
    logic [7:0] pl_addr, pl_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_err  (resp_err),
        .Read_Data (Read_Data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    // Byte memory model: 256 bytes, indexed by the low address byte.
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end

    function automatic logic [7:0] pat(input int i);
        return 8'(i) ^ 8'hA5;
    endfunction

    // One transaction from idle; samples every cycle after acceptance.
    task automatic do_txn(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd, output int resp_cyc, output int we_n,
                          output int re_n, output logic err, output int busy_ready,
                          output logic [63:0] a_first, output logic [63:0] a_last,
                          output int both);
        logic seen;
        seen = 1'b0; resp_cyc = 0; we_n = 0; re_n = 0; err = 1'b0; busy_ready = 0;
        a_first = '0; a_last = '0; both = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20 && resp_cyc == 0; c++) begin
            @(negedge clk);
            if (mem_we) we_n++;
            if (mem_re) re_n++;
            if (mem_we && mem_re) both++;
            if (mem_we || mem_re) begin
                if (!seen) a_first = mem_addr;
                a_last = mem_addr;
                seen = 1'b1;
            end
            if (req_ready) busy_ready++;
            if (resp_valid) begin
                resp_cyc = c;
                err = resp_err;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pl_en = 1'b1; pl_addr = 8'(i);
            case (i)
                0: pl_data = 8'h83;  1: pl_data = 8'h34;  2: pl_data = 8'h05;
                3: pl_data = 8'h0F;  4: pl_data = 8'hB3;  5: pl_data = 8'h84;
                6: pl_data = 8'h9A;  7: pl_data = 8'h00;
                default: pl_data = pat(i);
            endcase
        end
        @(negedge clk);
        pl_en = 1'b0;
        total++;
        if ({req_ready, resp_valid, resp_err, mem_we, mem_re} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_flags: got rdy/rv/err/we/re=%b want 10000",
                     {req_ready, resp_valid, resp_err, mem_we, mem_re});
        end
        total++;
        if (Read_Data !== 64'd0 || mem_addr !== 64'd0 || mem_wdata !== 8'd0) begin
            bad++;
            $display("FAIL reset_data: got rd=%h addr=%h wd=%h want zeros",
                     Read_Data, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loads;
        logic [2:0]  f3s   [6] = '{3'b011, 3'b000, 3'b100, 3'b001, 3'b110, 3'b010};
        logic [63:0] addrs [6] = '{64'd0, 64'd0, 64'd0, 64'd4, 64'd4, 64'd0};
        logic [63:0] exps  [6] = '{64'h009A84B3_0F053483, 64'hFFFFFFFF_FFFFFF83,
                                   64'h00000000_00000083, 64'hFFFFFFFF_FFFF84B3,
                                   64'h00000000_009A84B3, 64'h00000000_0F053483};
        int          ns    [6] = '{8, 1, 1, 2, 4, 4};
        int rc, wn, rn, br, bo;
        logic er;
        logic [63:0] af, al;
        for (int i = 0; i < 6; i++) begin
            do_txn(1'b0, f3s[i], addrs[i], 64'd0, rc, wn, rn, er, br, af, al, bo);
            total++;
            if (Read_Data !== exps[i] || er !== 1'b0) begin
                bad++;
                $display("FAIL load%0d_data: got rd=%h err=%b want rd=%h err=0",
                         i, Read_Data, er, exps[i]);
            end
            total++;
            if (rc !== ns[i] + 1 || rn !== ns[i] || wn !== 0 || br !== 0 || bo !== 0) begin
                bad++;
                $display("FAIL load%0d_timing: got resp=%0d re=%0d we=%0d rdy=%0d both=%0d want resp=%0d re=%0d we=0 rdy=0 both=0",
                         i, rc, rn, wn, br, bo, ns[i] + 1, ns[i]);
            end
        end
    endtask

    task automatic test_store;
        int rc, wn, rn, br, bo;
        logic er;
        logic [63:0] af, al;
        do_txn(1'b1, 3'b010, 64'd3, 64'h1122_3344_5566_7788, rc, wn, rn, er, br, af, al, bo);
        total++;
        if ({mem[3], mem[4], mem[5], mem[6]} !== 32'h88776655) begin
            bad++;
            $display("FAIL sw_bytes: got %h%h%h%h want 88776655", mem[3], mem[4], mem[5], mem[6]);
        end
        total++;
        if (mem[2] !== 8'h05 || mem[7] !== 8'h00) begin
            bad++;
            $display("FAIL sw_neighbours: got b2=%h b7=%h want 05 00", mem[2], mem[7]);
        end
        total++;
        if (wn !== 4 || rn !== 0 || rc !== 5 || er !== 1'b0) begin
            bad++;
            $display("FAIL sw_strobes: got we=%0d re=%0d resp=%0d err=%b want 4 0 5 0",
                     wn, rn, rc, er);
        end
        total++;
        if (Read_Data !== 64'h0F053483) begin
            bad++;
            $display("FAIL sw_rdata_held: got %h want 000000000f053483", Read_Data);
        end
    endtask

    task automatic test_errors;
        int rc, wn, rn, br, bo;
        logic er;
        logic [63:0] af, al;
        do_txn(1'b0, 3'b111, 64'd0, 64'd0, rc, wn, rn, er, br, af, al, bo);
        total++;
        if (rc !== 1 || er !== 1'b1 || wn !== 0 || rn !== 0) begin
            bad++;
            $display("FAIL ld111: got resp=%0d err=%b we=%0d re=%0d want 1 1 0 0", rc, er, wn, rn);
        end
        do_txn(1'b1, 3'b100, 64'd0, 64'hFF, rc, wn, rn, er, br, af, al, bo);
        total++;
        if (rc !== 1 || er !== 1'b1 || wn !== 0 || rn !== 0 || mem[0] !== 8'h83) begin
            bad++;
            $display("FAIL sb100: got resp=%0d err=%b we=%0d re=%0d m0=%h want 1 1 0 0 83",
                     rc, er, wn, rn, mem[0]);
        end
        total++;
        if (Read_Data !== 64'h0F053483) begin
            bad++;
            $display("FAIL err_rdata_held: got %h want 000000000f053483", Read_Data);
        end
    endtask

    task automatic test_back_to_back;
        int r1, r2, rdy_n, rdy_at;
        r1 = 0; r2 = 0; rdy_n = 0; rdy_at = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
        req_addr = 64'h10; req_wdata = 64'hBEEF;
        @(posedge clk);
        #1 req_write = 1'b0; req_funct3 = 3'b101; req_wdata = '0;
        for (int c = 1; c <= 20 && r2 == 0; c++) begin
            @(negedge clk);
            if (req_ready) begin
                rdy_n++;
                rdy_at = c;
            end
            if (resp_valid) begin
                if (r1 == 0) r1 = c;
                else begin
                    r2 = c;
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        total++;
        if (r1 !== 3 || r2 !== 7 || rdy_n !== 1 || rdy_at !== 4) begin
            bad++;
            $display("FAIL b2b_timing: got r1=%0d r2=%0d rdy_n=%0d rdy_at=%0d want 3 7 1 4",
                     r1, r2, rdy_n, rdy_at);
        end
        total++;
        if (Read_Data !== 64'hBEEF || mem[16] !== 8'hEF || mem[17] !== 8'hBE) begin
            bad++;
            $display("FAIL b2b_data: got rd=%h m10=%h m11=%h want beef ef be",
                     Read_Data, mem[16], mem[17]);
        end
    endtask

    task automatic test_wrap;
        int rc, wn, rn, br, bo;
        logic er;
        logic [63:0] af, al;
        do_txn(1'b0, 3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, rc, wn, rn, er, br, af, al, bo);
        total++;
        if (af !== 64'hFFFF_FFFF_FFFF_FFFF || al !== 64'd0) begin
            bad++;
            $display("FAIL wrap_addr: got first=%h last=%h want ffffffffffffffff 0", af, al);
        end
        total++;
        if (Read_Data !== 64'h835A || er !== 1'b0 || rc !== 3) begin
            bad++;
            $display("FAIL wrap_data: got rd=%h err=%b resp=%0d want 835a 0 3", Read_Data, er, rc);
        end
    endtask

    task automatic test_reset_abort;
        int rv_n;
        rv_n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b011;
        req_addr = 64'd8; req_wdata = 64'h0102_0304_0506_0708;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({req_ready, resp_valid, resp_err, mem_we, mem_re} !== 5'b10000 ||
            Read_Data !== 64'd0 || mem_addr !== 64'd0 || mem_wdata !== 8'd0) begin
            bad++;
            $display("FAIL abort_outputs: got flags=%b rd=%h addr=%h wd=%h want 10000 0 0 0",
                     {req_ready, resp_valid, resp_err, mem_we, mem_re},
                     Read_Data, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (resp_valid) rv_n++;
        end
        total++;
        if (rv_n !== 0) begin
            bad++;
            $display("FAIL abort_no_resp: got %0d resp pulses want 0", rv_n);
        end
        total++;
        if (mem[8] !== 8'h08 || mem[9] !== pat(9) || mem[15] !== pat(15)) begin
            bad++;
            $display("FAIL abort_bytes: got m8=%h m9=%h m15=%h want 08 %h %h",
                     mem[8], mem[9], mem[15], pat(9), pat(15));
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store();
        test_errors();
        test_back_to_back();
        test_wrap();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
